// File: rtl/wb_drain_ctrl_pkg.sv
// Shared definitions for the write-buffer drain controller.
//   - FSM state encoding
//   - Bit positions of the fields inside a write-buffer entry
//   - Default entry width (address + data + byte enables)
package wb_drain_ctrl_pkg;

    localparam int unsigned WB_ENTRY_W = 68;

    // Entry layout: {addr[31:0], data[31:0], be[3:0]}
    localparam int unsigned ADDR_MSB = 67;
    localparam int unsigned ADDR_LSB = 36;
    localparam int unsigned DATA_MSB = 35;
    localparam int unsigned DATA_LSB = 4;
    localparam int unsigned BE_MSB   = 3;
    localparam int unsigned BE_LSB   = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrReq = 2'd1,
        StRdReq = 2'd2
    } state_e;

endpackage

// File: rtl/wb_drain_ctrl_sat_counter.sv
// Saturating up-counter used for the drained-write performance count.
//   clk     : clock
//   rst_n   : asynchronous active-low reset, clears the count
//   inc_in  : increment request for this cycle
//   cnt_out : current count, sticks at all ones
module wb_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_in,
    output logic [CNT_W-1:0] cnt_out
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_in && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_out = cnt_q;

endmodule

// File: rtl/wb_drain_ctrl.sv
// Write-buffer drain controller. Pops store entries from the write buffer and
// issues them as single-word writes on the memory port; also forwards cache
// read misses on the same port, always after every buffered write.
//   wb_*   : write-buffer head entry, empty flag and pop strobe
//   rd_*   : cache read-miss request / return
//   mem_*  : shared memory port (req held until ack)
//   busy_out      : controller active or buffer not empty
//   drain_cnt_out : saturating count of completed writes
module wb_drain_ctrl
    import wb_drain_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BE_W    = 4,
    parameter int unsigned ENTRY_W = WB_ENTRY_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_empty_in,
    input  logic [ENTRY_W-1:0] wb_data_in,
    output logic               wb_pop_out,
    input  logic               rd_req_in,
    input  logic [ADDR_W-1:0]  rd_addr_in,
    output logic [DATA_W-1:0]  rd_data_out,
    output logic               rd_valid_out,
    output logic               mem_req_out,
    output logic               mem_we_out,
    output logic [ADDR_W-1:0]  mem_addr_out,
    output logic [DATA_W-1:0]  mem_wdata_out,
    output logic [BE_W-1:0]    mem_be_out,
    input  logic [DATA_W-1:0]  mem_rdata_in,
    input  logic               mem_ack_in,
    output logic               busy_out,
    output logic [CNT_W-1:0]   drain_cnt_out
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              pop;
    logic              drain_inc;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        pop         = 1'b0;
        drain_inc   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Writes always win so a read never overtakes a buffered store.
                if (!wb_empty_in) begin
                    pop         = 1'b1;
                    mem_addr_d  = wb_data_in[ADDR_MSB:ADDR_LSB];
                    mem_wdata_d = wb_data_in[DATA_MSB:DATA_LSB];
                    mem_be_d    = wb_data_in[BE_MSB:BE_LSB];
                    state_d     = StWrReq;
                end else if (rd_req_in && !rd_valid_q) begin
                    // rd_req_in is still high while rd_valid_out pulses; skip it.
                    mem_addr_d = rd_addr_in;
                    mem_be_d   = '1;
                    state_d    = StRdReq;
                end
            end
            StWrReq: begin
                if (mem_ack_in) begin
                    drain_inc = 1'b1;
                    if (!wb_empty_in) begin
                        pop         = 1'b1;
                        mem_addr_d  = wb_data_in[ADDR_MSB:ADDR_LSB];
                        mem_wdata_d = wb_data_in[DATA_MSB:DATA_LSB];
                        mem_be_d    = wb_data_in[BE_MSB:BE_LSB];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRdReq: begin
                if (mem_ack_in) begin
                    rd_data_d  = mem_rdata_in;
                    rd_valid_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        mem_req_d = (state_d != StIdle);
        mem_we_d  = (state_d == StWrReq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    wb_sat_counter #(
        .CNT_W (CNT_W)
    ) u_drain_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_in  (drain_inc),
        .cnt_out (drain_cnt_out)
    );

    // Gated by rst_n so the buffer is never popped while we are held in reset.
    assign wb_pop_out    = pop && rst_n;
    assign busy_out      = rst_n && ((state_q != StIdle) || !wb_empty_in);
    assign mem_req_out   = mem_req_q;
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign mem_be_out    = mem_be_q;
    assign rd_data_out   = rd_data_q;
    assign rd_valid_out  = rd_valid_q;

endmodule

// File: doc/wb_drain_ctrl.md
Name: wb_drain_ctrl

Overview:
- Sits directly downstream of the 4-entry write buffer FIFO. Pops buffered store entries and issues them as single-word writes on the shared main-memory port.
- Also carries the data cache's read-miss requests onto the same port. Reads are ordered strictly after all buffered writes, which keeps memory coherent with the buffer contents.
- Provides a busy indication and a saturating drain counter for performance monitoring.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- ENTRY_W, 68, write-buffer entry width (ADDR_W+DATA_W+BE_W).
- CNT_W, 16, width of the drained-write performance counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_empty_in  in  1  write buffer empty flag.
- wb_data_in  in  ENTRY_W  head entry of the write buffer: [67:36] address, [35:4] data, [3:0] byte enables.
- wb_pop_out  out  1  one-cycle pop strobe to the write buffer.
- rd_req_in  in  1  cache read-miss request; held high until rd_valid_out.
- rd_addr_in  in  ADDR_W  read address, stable while rd_req_in is high.
- rd_data_out  out  DATA_W  read return data.
- rd_valid_out  out  1  one-cycle pulse; rd_data_out is valid.
- mem_req_out  out  1  memory request; held until acknowledged.
- mem_we_out  out  1  1 = write, 0 = read.
- mem_addr_out  out  ADDR_W  memory address.
- mem_wdata_out  out  DATA_W  write data.
- mem_be_out  out  BE_W  write byte enables; all ones on reads.
- mem_rdata_in  in  DATA_W  read data, valid with mem_ack_in on a read.
- mem_ack_in  in  1  memory accepts/completes the request; ignored when mem_req_out=0.
- busy_out  out  1  state != IDLE or wb_empty_in=0.
- drain_cnt_out  out  CNT_W  number of completed writes, saturating.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Every registered output, including rd_data_out and drain_cnt_out, is 0. Captured address, data and byte-enable registers are 0.
- Reset mid-transaction aborts the transaction with no completion. An already-popped entry is lost.
- FSM states: IDLE, WR_REQ, RD_REQ.
- IDLE, wb_empty_in=0 (writes always win):
  - Capture wb_data_in into mem_addr/wdata/be registers.
  - Assert wb_pop_out combinationally in this same cycle.
  - Next state WR_REQ.
- IDLE, wb_empty_in=1 and rd_req_in=1:
  - Capture rd_addr_in.
  - Next state RD_REQ.
- WR_REQ:
  - mem_req_out=1, mem_we_out=1. Outputs hold stable until mem_ack_in.
  - On ack: drain_cnt_out increments and saturates at all ones.
  - On ack with wb_empty_in=0: capture the next entry, pop in the same cycle, stay in WR_REQ (back-to-back, 1 write per ack).
  - On ack with wb_empty_in=1: next state IDLE.
- RD_REQ:
  - mem_req_out=1, mem_we_out=0, mem_be_out=all ones.
  - On ack: register mem_rdata_in into rd_data_out, pulse rd_valid_out for 1 cycle, next state IDLE.
  - New writes arriving during RD_REQ wait until the read completes.
- wb_pop_out is asserted only when wb_empty_in=0. There is never more than one pop per cycle.
- Latency:
  - Write: pop cycle, then mem_req_out high from the next cycle.
  - Read: request seen in IDLE, mem_req_out next cycle, rd_valid_out the cycle after ack.
- mem_ack_in in the same cycle mem_req_out first rises is legal: 1-cycle transaction.
- rd_req_in held across rd_valid_out is not re-issued. IDLE ignores rd_req_in in the cycle rd_valid_out is high.
- mem_rdata_in is ignored on write acks.

Decomposition:
- Shared package:
  - State encoding constants (IDLE/WR_REQ/RD_REQ).
  - Entry field bit positions (ADDR_MSB=67, ADDR_LSB=36, DATA_MSB=35, DATA_LSB=4, BE_MSB=3).
  - ENTRY_W.
- Sub-module wb_sat_counter: CNT_W saturating increment counter with async active-low reset. Everything else stays flat.

Test Plan:
- Reset with wb_empty_in=0 and mem_ack_in=1 -> all outputs 0, no pop. Release reset -> pop plus capture in the first cycle, mem_req_out=1 the next cycle.
- One entry {addr=0x1000_0000, data=0xDEADBEEF, be=0xF}, ack after 3 cycles -> mem_addr/wdata/be held stable for 3 cycles, drain_cnt_out=1, return to IDLE.
- Four entries, ack every cycle -> exactly 4 pops, 4 writes in order with no bubble, drain_cnt_out=4.
- rd_req_in=1 (addr 0x2000) while 2 writes are buffered -> both writes complete first, then a read with mem_we_out=0. mem_rdata_in=0xCAFEF00D gives rd_valid_out pulse with rd_data_out=0xCAFEF00D.
- Write enters the buffer during RD_REQ -> read completes first, write issues after IDLE. No pop before rd_valid_out.
- Preset counter near max (CNT_W=4 build), 17 writes -> drain_cnt_out saturates at 15. Assert rst_n=0 during WR_REQ -> mem_req_out drops immediately, counter=0.
